// File: rtl/knight_cmd_pkg.sv
// ---------------------------------------------------------------------------
// knight_cmd_pkg
// Shared definitions for the Knight command sequencer:
//   - command opcodes and heading constants for the 16-bit command word
//     {opcode[15:12], heading[11:4], squares[3:0]}
//   - positive acknowledge byte returned by the Knight
//   - sequencer FSM state and error-code enumerations
//   - make_cmd(): packs the three command fields into a word
// ---------------------------------------------------------------------------
package knight_cmd_pkg;

  localparam logic [15:0] CAL_GYRO   = 16'h2000;
  localparam logic [3:0]  OP_MOVE    = 4'h4;
  localparam logic [3:0]  OP_FANFARE = 4'h5;
  localparam logic [3:0]  OP_TOUR    = 4'h6;

  localparam logic [7:0]  NORTH      = 8'h00;
  localparam logic [7:0]  WEST       = 8'h3F;
  localparam logic [7:0]  SOUTH      = 8'h7F;
  localparam logic [7:0]  EAST       = 8'hBF;

  localparam logic [7:0]  POS_ACK    = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_SNT  = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_ERR       = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } err_code_t;

  function automatic logic [15:0] make_cmd(input logic [3:0] opcode,
                                           input logic [7:0] heading,
                                           input logic [3:0] squares);
    return {opcode, heading, squares};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Circular command queue, DEPTH entries of W bits.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_push, i_din  : enqueue i_din (dropped and overflow set when full,
//                    unless a pop frees a slot in the same cycle)
//   i_pop          : dequeue the head (ignored when empty)
//   i_flush        : empty the queue and clear overflow (wins over push/pop)
//   o_head         : current head word
//   o_full, o_empty, o_count, o_overflow : status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         r_overflow;

  logic         w_do_pop;
  logic         w_do_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

  // A pop in the same cycle frees a slot, so a push into a full queue
  // is still accepted then and occupancy stays constant.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_do_push) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// ---------------------------------------------------------------------------
// cmd_sequencer
// Queues 16-bit Knight commands and issues them to RemoteComm one at a
// time, waiting for the Knight's acknowledge byte after each one. Halts in
// ERR on NACK, response timeout or abort.
//   clk, rst_n              : clock, asynchronous active-low reset
//   push, push_cmd          : enqueue a command word
//   start, abort, clr_err,
//   flush                   : control pulses
//   full, empty, count,
//   overflow                : queue status
//   snd_cmd, cmd            : request to RemoteComm and the word to send
//   cmd_snt, resp_rdy, resp : RemoteComm transmit-done and response byte
//   busy, done, err,
//   err_code, cmds_done     : sequencer status
// ---------------------------------------------------------------------------
module cmd_sequencer
  import knight_cmd_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [7:0]  ACK_BYTE     = 8'hA5,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [15:0]              push_cmd,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     clr_err,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     snd_cmd,
  output logic [15:0]              cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [7:0]               cmds_done
);

  seq_state_t  r_state;
  seq_state_t  w_state_next;
  err_code_t   r_err_code;
  err_code_t   w_err_code_next;
  logic [15:0] r_cmd;
  logic [31:0] r_tmo_cnt;
  logic [31:0] w_tmo_cnt_next;
  logic [7:0]  r_cmds_done;
  logic [7:0]  w_cmds_done_next;
  logic        r_done;
  logic        w_done_next;

  logic        w_pop;
  logic        w_flush;
  logic        w_ack;
  logic        w_tmo_hit;
  logic [15:0] w_head;

  // Flushing while a command is in flight would pull entries out from
  // under the FSM, so it is only honoured when the sequencer is parked.
  assign w_flush = flush && ((r_state == ST_IDLE) || (r_state == ST_ERR));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (push),
    .i_din      (push_cmd),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_head     (w_head),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign w_ack = resp_rdy && (resp == ACK_BYTE);
  // ">=" rather than "==": cmd_snt arriving on the last allowed cycle moves
  // to WAIT_RESP with the count already past the limit, and that must still
  // time out on the next cycle without a response.
  assign w_tmo_hit = (r_tmo_cnt >= (TIMEOUT_CLKS - 32'd1));

  always_comb begin
    w_state_next     = r_state;
    w_err_code_next  = r_err_code;
    w_tmo_cnt_next   = r_tmo_cnt;
    w_cmds_done_next = r_cmds_done;
    w_done_next      = 1'b0;
    w_pop            = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cmds_done_next = 8'd0;
          if (empty) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = ST_LOAD;
          end
        end
      end

      // An abort here leaves the head entry queued rather than losing it.
      ST_LOAD: begin
        if (abort) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_ABORT;
        end else begin
          w_pop        = 1'b1;
          w_state_next = ST_SEND;
        end
      end

      ST_SEND: begin
        w_tmo_cnt_next = 32'd0;
        if (abort) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_ABORT;
        end else begin
          w_state_next = ST_WAIT_SNT;
        end
      end

      ST_WAIT_SNT: begin
        w_tmo_cnt_next = r_tmo_cnt + 32'd1;
        if (abort) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_ABORT;
        end else if (cmd_snt) begin
          w_state_next = ST_WAIT_RESP;
        end else if (w_tmo_hit) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_TIMEOUT;
        end
      end

      ST_WAIT_RESP: begin
        w_tmo_cnt_next = r_tmo_cnt + 32'd1;
        if (abort) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_ABORT;
        end else if (resp_rdy) begin
          if (w_ack) begin
            if (r_cmds_done != 8'hFF) w_cmds_done_next = r_cmds_done + 8'd1;
            if (empty) begin
              w_done_next  = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_LOAD;
            end
          end else begin
            w_state_next    = ST_ERR;
            w_err_code_next = ERR_NACK;
          end
        end else if (w_tmo_hit) begin
          w_state_next    = ST_ERR;
          w_err_code_next = ERR_TIMEOUT;
        end
      end

      ST_ERR: begin
        if (clr_err) begin
          w_state_next    = ST_IDLE;
          w_err_code_next = ERR_NONE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_err_code  <= ERR_NONE;
      r_cmd       <= 16'h0000;
      r_tmo_cnt   <= 32'd0;
      r_cmds_done <= 8'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_err_code  <= w_err_code_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
      r_cmds_done <= w_cmds_done_next;
      r_done      <= w_done_next;
      if (w_pop) r_cmd <= w_head;
    end
  end

  assign cmd       = r_cmd;
  assign snd_cmd   = (r_state == ST_SEND);
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_SEND) ||
                     (r_state == ST_WAIT_SNT) || (r_state == ST_WAIT_RESP);
  assign err       = (r_state == ST_ERR);
  assign err_code  = r_err_code;
  assign done      = r_done;
  assign cmds_done = r_cmds_done;

endmodule

// File: tb/tb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cmd_sequencer
// Drives cmd_sequencer with directed scenarios followed by randomized
// command batches. A queue-based reference model holds the commands the
// host expects to see issued, the acked count and the overflow flag.
// ---------------------------------------------------------------------------
module tb_cmd_sequencer;
  import knight_cmd_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [15:0]   push_cmd;
  logic          start;
  logic          abort;
  logic          clr_err;
  logic          flush;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          snd_cmd;
  logic [15:0]   cmd;
  logic          cmd_snt;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [7:0]    cmds_done;

  cmd_sequencer #(
    .DEPTH        (DEPTH),
    .ACK_BYTE     (POS_ACK),
    .TIMEOUT_CLKS (32'(TMO))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_cmd  (push_cmd),
    .start     (start),
    .abort     (abort),
    .clr_err   (clr_err),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .snd_cmd   (snd_cmd),
    .cmd       (cmd),
    .cmd_snt   (cmd_snt),
    .resp_rdy  (resp_rdy),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cmds_done (cmds_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [15:0] m_q[$];
  bit          m_ovf;
  int          m_cd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_empty"},     32'(empty), 32'd1);
    chk({tag, "_full"},      32'(full), 32'd0);
    chk({tag, "_count"},     32'(count), 32'd0);
    chk({tag, "_overflow"},  32'(overflow), 32'd0);
    chk({tag, "_snd_cmd"},   32'(snd_cmd), 32'd0);
    chk({tag, "_cmd"},       32'(cmd), 32'h0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_err"},       32'(err), 32'd0);
    chk({tag, "_err_code"},  32'(err_code), 32'd0);
    chk({tag, "_cmds_done"}, 32'(cmds_done), 32'd0);
  endtask

  task automatic check_queue(input string tag);
    chk({tag, "_count"},    32'(count), 32'(m_q.size()));
    chk({tag, "_empty"},    32'(empty), 32'(m_q.size() == 0));
    chk({tag, "_full"},     32'(full), 32'(m_q.size() == DEPTH));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic push_word(input logic [15:0] w);
    push = 1'b1;
    push_cmd = w;
    tick();
    push = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back(w);
    else m_ovf = 1'b1;
  endtask

  // Only used from IDLE: start clears the acked counter.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_cd = 0;
  endtask

  task automatic wait_snd();
    for (int i = 0; i < 20 && !snd_cmd; i++) tick();
    chk("snd_cmd_seen", 32'(snd_cmd), 32'd1);
    if (!snd_cmd) summary();
  endtask

  task automatic clear_error();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_code", 32'(err_code), 32'd0);
  endtask

  // Entered while snd_cmd is visible. Plays RemoteComm: cmd_snt after d1
  // cycles, then the response byte after d2 more. With spur set, a stray
  // NACK byte is shown during WAIT_SNT and must be ignored.
  task automatic issue(input logic [7:0] rb, input int d1, input int d2, input bit spur);
    logic [15:0] exp;
    exp = m_q.pop_front();
    chk("cmd", 32'(cmd), 32'(exp));
    $display("txn cmd=%h resp=%h snt_dly=%0d resp_dly=%0d", cmd, rb, d1, d2);
    tick();
    chk("snd_pulse_len", 32'(snd_cmd), 32'd0);
    for (int i = 0; i < d1; i++) begin
      resp_rdy = spur && (i == 0);
      resp = 8'h5A;
      tick();
    end
    resp_rdy = 1'b0;
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (d2) tick();
    resp_rdy = 1'b1;
    resp = rb;
    tick();
    resp_rdy = 1'b0;
    if (rb == POS_ACK) begin
      if (m_cd < 255) m_cd++;
      chk("ack_cmds_done", 32'(cmds_done), 32'(m_cd));
      chk("ack_err", 32'(err), 32'd0);
      if (m_q.size() == 0) begin
        chk("drain_done", 32'(done), 32'd1);
        chk("drain_busy", 32'(busy), 32'd0);
        tick();
        chk("done_pulse_len", 32'(done), 32'd0);
      end else begin
        chk("next_busy", 32'(busy), 32'd1);
      end
    end else begin
      chk("nack_err", 32'(err), 32'd1);
      chk("nack_code", 32'(err_code), 32'(ERR_NACK));
      chk("nack_cmd", 32'(cmd), 32'(exp));
      chk("nack_count", 32'(count), 32'(m_q.size()));
      chk("nack_cmds_done", 32'(cmds_done), 32'(m_cd));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [15:0] w;
    rst_n = 1'b0; push = 1'b0; push_cmd = 16'h0; start = 1'b0; abort = 1'b0;
    clr_err = 1'b0; flush = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = 8'h0;
    m_ovf = 1'b0; m_cd = 0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Empty start: immediate done pulse
    do_start();
    chk("empty_start_done", 32'(done), 32'd1);
    tick();
    chk("empty_start_done_low", 32'(done), 32'd0);

    // Ack path
    push_word(CAL_GYRO);
    push_word(make_cmd(OP_FANFARE, WEST, 4'h4));
    push_word(make_cmd(OP_MOVE, SOUTH, 4'h1));
    check_queue("ack_fill");
    do_start();
    for (int i = 0; i < 3; i++) begin
      wait_snd();
      issue(POS_ACK, i, 2 - i, 1'b0);
    end
    chk("ack_total", 32'(cmds_done), 32'd3);
    check_queue("ack_end");

    // NACK path, then resume
    push_word(16'h53F4);
    push_word(16'h5BF4);
    push_word(16'h47F1);
    do_start();
    wait_snd();
    issue(POS_ACK, 1, 1, 1'b0);
    wait_snd();
    issue(8'h5A, 2, 0, 1'b0);
    chk("nack_cmd_5bf4", 32'(cmd), 32'h5BF4);
    clear_error();
    do_start();
    wait_snd();
    issue(POS_ACK, 0, 3, 1'b0);

    // Timeout: error exactly TMO clocks after the snd_cmd cycle
    push_word(16'h47F1);
    do_start();
    wait_snd();
    w = m_q.pop_front();
    chk("tmo_cmd", 32'(cmd), 32'(w));
    n = 0;
    while (!err && n < 300) begin
      cmd_snt = (n == 3);
      tick();
      n++;
    end
    cmd_snt = 1'b0;
    chk("tmo_latency", 32'(n), 32'(TMO + 1));
    chk("tmo_code", 32'(err_code), 32'(ERR_TIMEOUT));
    chk("tmo_cmd_held", 32'(cmd), 32'h47F1);
    clear_error();

    // Response on the last allowed cycle wins over the timeout
    push_word(16'h47F1);
    do_start();
    wait_snd();
    w = m_q.pop_front();
    for (int k = 1; k <= TMO + 1; k++) begin
      cmd_snt = (k == 4);
      resp_rdy = (k == TMO + 1);
      resp = POS_ACK;
      tick();
    end
    cmd_snt = 1'b0;
    resp_rdy = 1'b0;
    m_cd++;
    chk("late_ack_err", 32'(err), 32'd0);
    chk("late_ack_done", 32'(done), 32'd1);
    chk("late_ack_cmds_done", 32'(cmds_done), 32'(m_cd));
    tick();

    // Overflow, simultaneous push/pop, abort in WAIT_SNT, flush
    for (int i = 0; i < DEPTH + 1; i++) push_word(16'h4000 + 16'(i));
    check_queue("ovf");
    do_start();
    push = 1'b1;
    push_cmd = 16'h6123;
    tick();
    push = 1'b0;
    wait_snd();
    w = m_q.pop_front();
    chk("ovf_head", 32'(cmd), 32'(w));
    m_q.push_back(16'h6123);
    check_queue("pushpop");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_snt_err", 32'(err), 32'd1);
    chk("abort_snt_code", 32'(err_code), 32'(ERR_ABORT));
    clear_error();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    check_queue("flush");

    // Abort coincident with a positive response: abort wins
    push_word(16'h53F4);
    do_start();
    wait_snd();
    w = m_q.pop_front();
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    resp_rdy = 1'b1;
    resp = POS_ACK;
    abort = 1'b1;
    tick();
    resp_rdy = 1'b0;
    abort = 1'b0;
    chk("abort_ack_code", 32'(err_code), 32'(ERR_ABORT));
    chk("abort_ack_cmds_done", 32'(cmds_done), 32'(m_cd));
    clear_error();

    // Asynchronous reset while in WAIT_SNT
    push_word(CAL_GYRO);
    push_word(16'h47F1);
    do_start();
    wait_snd();
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_q.delete();
    m_ovf = 1'b0;
    m_cd = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized batches
    for (int r = 0; r < 14; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        w = make_cmd(4'($urandom_range(2, 6)), 8'($urandom), 4'($urandom));
        push_word(w);
      end
      check_queue("rnd_fill");
      if (m_q.size() == 0) continue;
      do_start();
      while (m_q.size() > 0) begin
        bit nack;
        nack = ($urandom_range(0, 7) == 0);
        wait_snd();
        issue(nack ? 8'($urandom_range(0, 164)) : POS_ACK,
              $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        if (nack) begin
          clear_error();
          break;
        end
      end
      if (m_ovf && $urandom_range(0, 1) == 1) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        check_queue("rnd_flush");
      end
    end

    summary();
  end

endmodule
